// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// Entry M drives the memory-stage outputs; entry S absorbs the one extra beat
// that can arrive while the memory stage is stalled. ex_ready_o is decoded
// purely from registered state, so mem_ready_i never reaches it combinationally.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic              Zero_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [RD_W-1:0]   RDaddr_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic              Zero_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [RD_W-1:0]   RDaddr_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Packed payload: {ALUResult, Zero, RS2data, RDaddr, RegWrite, MemtoReg, MemRead, MemWrite}
    localparam int PW = 2 * DATA_W + RD_W + 5;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // State encoding doubles as the valid bits: bit 0 = M.valid, bit 1 = S.valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [PW-1:0]     m_payload_reg;
    logic [PW-1:0]     s_payload_reg;
    logic [PW-1:0]     in_payload;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              accept;
    logic              pop;
    logic              load_m_from_in;
    logic              load_m_from_s;
    logic              load_s;
    logic              reg_write_cap;

    // Writes to x0 are architecturally meaningless, so drop RegWrite for rd == 0.
    assign reg_write_cap = RegWrite_i & (RDaddr_i != '0);
    assign in_payload    = {ALUResult_i, Zero_i, RS2data_i, RDaddr_i,
                            reg_write_cap, MemtoReg_i, MemRead_i, MemWrite_i};

    assign accept = ex_valid_i & ex_ready_o & ~flush_i;
    assign pop    = mem_valid_o & mem_ready_i;

    // State register: valid bits of M and S.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and entry-load decisions.
    always_comb begin
        state_next     = state_reg;
        load_m_from_in = 1'b0;
        load_m_from_s  = 1'b0;
        load_s         = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next     = ST_ONE;
                    load_m_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_m_from_in = 1'b1;
                end else if (accept) begin
                    state_next = ST_FULL;
                    load_s     = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // ex_ready_o is low here, so only a pop can happen.
                if (pop) begin
                    state_next    = ST_ONE;
                    load_m_from_s = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Handshake and status outputs, decoded from the state register only.
    always_comb begin
        ex_ready_o  = ~state_reg[1];
        mem_valid_o = state_reg[0];
        occupancy_o = {1'b0, state_reg[0]} + {1'b0, state_reg[1]};
    end

    // Payload storage; held entries are never flushed, only overwritten on load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_payload_reg <= '0;
            s_payload_reg <= '0;
        end else begin
            if (load_m_from_in) begin
                m_payload_reg <= in_payload;
            end else if (load_m_from_s) begin
                m_payload_reg <= s_payload_reg;
            end
            if (load_s) begin
                s_payload_reg <= in_payload;
            end
        end
    end

    // Saturating count of cycles in which a valid beat waits on the memory stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else if (mem_valid_o && !mem_ready_i && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

    assign {ALUResult_o, Zero_o, RS2data_o, RDaddr_o,
            RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} = m_payload_reg;

endmodule
